copro_result_buffer: RTL and testbench
======================================

# copro_result_buffer

Result-queue stage directly downstream of the coprocessor ALU in the CV-X-IF example coprocessor. It captures every registered ALU result (value, hartid, id, rd, we) into an in-order FIFO and presents it to the core on the CV-X-IF result channel with a valid/ready handshake. It also generates the issue-side `issue_ready_o` credit signal. The ALU has no backpressure, so this signal must account for the instruction currently in flight inside the ALU.

## Interface
- `XLEN`, 32, result data width
- `DEPTH`, 4, FIFO entries; power of two, ≥2
- `hartid_t`, logic, hart identifier type
- `id_t`, logic, instruction identifier type

Ports:
- `clk_i` in 1: clock; single clock domain
- `rst_i` in 1: reset; synchronous, active-high
- `issue_valid_i` in 1: issue stage hands an instruction to the ALU this cycle
- `issue_ready_o` out 1: buffer guarantees space for one more ALU result
- `alu_valid_i` in 1: ALU result valid (registered ALU output)
- `alu_result_i` in XLEN: ALU result value
- `alu_hartid_i` in hartid_t: hart of result
- `alu_id_i` in id_t: instruction id
- `alu_rd_i` in 5: destination register
- `alu_we_i` in 1: write-enable (0 for NOP)
- `result_valid_o` out 1: result channel valid
- `result_ready_i` in 1: core accepts result
- `result_data_o` out XLEN: head entry value
- `result_hartid_o` out hartid_t: head entry hartid
- `result_id_o` out id_t: head entry id
- `result_rd_o` out 5: head entry rd
- `result_we_o` out 1: head entry we
- `count_o` out $clog2(DEPTH)+1: occupied entries
- `overflow_o` out 1: sticky; a push was dropped

## Operation
- The FIFO is circular, with `wr_ptr` and `rd_ptr` of $clog2(DEPTH) bits each. Both pointers wrap modulo DEPTH. `count` is tracked explicitly (0..DEPTH).
- Push condition: `alu_valid_i`. Pop condition: `result_valid_o & result_ready_i`.
- A push is accepted when `count < DEPTH` or when a pop occurs in the same cycle.
  - If neither holds, the push is dropped and `overflow_o` is set. It stays set until reset.
  - Pointers and count are unchanged by a dropped push.
- Simultaneous accepted push and pop: count is unchanged and both pointers advance.
- In-flight tracking: `inflight_q <= issue_valid_i & issue_ready_o`, cleared by reset.
- `issue_ready_o = (count + inflight_q) < DEPTH` (combinational).
  - With this credit rule, a compliant issuer can never overflow the buffer.
- NOP results (we=0, rd=0) are queued and returned like any other result. Every issued instruction produces exactly one result transaction.
- Ordering is strict FIFO. No reordering by hartid or id.
- Output fields are driven from the head entry, `mem[rd_ptr]`. While `result_valid_o`=1 and `result_ready_i`=0, all result fields hold stable.
- Reset mid-operation: all queued entries are discarded, and in-flight credit is discarded.
- Reset values: `result_valid_o`=0, `result_data_o`=0, `result_hartid_o`=0, `result_id_o`=0, `result_rd_o`=0, `result_we_o`=0, `count_o`=0, `overflow_o`=0, `issue_ready_o`=1 (DEPTH≥2). Storage array contents need not be reset, but outputs read as 0 while empty.

## Timing
- Registered path: an `alu_valid_i` at cycle t gives `result_valid_o` at t+1, provided the FIFO was empty at t.
- End-to-end: issue at t → ALU valid at t+1 → result at t+2.
- Throughput: one push and one pop per cycle, sustained.
- `issue_ready_o` drops in the same cycle that count+inflight reaches DEPTH. It rises in the cycle after the pop that frees space.
- `count_o` reflects the registered count, updated at the clock edge after the push or pop.

## Configuration
- `COPRO_RESULT_BYPASS_EN` defined:
  - When count==0 and `alu_valid_i`=1, the ALU fields drive the result outputs combinationally and `result_valid_o`=1 in the same cycle.
  - If `result_ready_i`=1 in that cycle, nothing is written and count stays 0. Otherwise the entry is written normally.
  - Latency from ALU valid to result is 0 cycles.
- Not defined: no combinational path from `alu_*` to `result_*`. Minimum latency is 1 cycle as above.

## Test plan
- Reset, then single ROR64H result {result=0xDEADBEEF, rd=5, id=3, we=1}, ready=1 → `result_valid_o` one cycle later with identical fields, then returns to 0. `count_o` sequence is 0,1,0.
- 4 back-to-back results with ready=0 (DEPTH=4) → `count_o`=4. `issue_ready_o`=0 from the cycle count+inflight=4. Release ready → results appear in order over 4 consecutive cycles.
- Full FIFO plus simultaneous push and pop → push accepted, `count_o` stays 4, `overflow_o`=0.
- Full FIFO, push with ready=0 → entry dropped, `overflow_o`=1 and sticky. Queued contents unchanged.
- NOP (we=0, rd=0, id=7) → result transaction with id=7, we=0, data=0.
- Assert `rst_i` with 3 entries queued → next cycle `result_valid_o`=0, `count_o`=0, `issue_ready_o`=1, `overflow_o`=0. With `COPRO_RESULT_BYPASS_EN`, an empty-FIFO push with ready=1 produces `result_valid_o` in the same cycle and count stays 0.

Source files
------------

// File: rtl/copro_result_buffer.sv
// In-order result FIFO between the coprocessor ALU and the CV-X-IF result channel, with issue credit.
// Optional macro COPRO_RESULT_BYPASS_EN: zero-latency path from ALU to result outputs when empty.
module copro_result_buffer #(
  parameter int unsigned XLEN     = 32,
  parameter int unsigned DEPTH    = 4,
  parameter type         hartid_t = logic,
  parameter type         id_t     = logic
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic                       issue_valid_i,
  output logic                       issue_ready_o,
  input  logic                       alu_valid_i,
  input  logic [XLEN-1:0]            alu_result_i,
  input  hartid_t                    alu_hartid_i,
  input  id_t                        alu_id_i,
  input  logic [4:0]                 alu_rd_i,
  input  logic                       alu_we_i,
  output logic                       result_valid_o,
  input  logic                       result_ready_i,
  output logic [XLEN-1:0]            result_data_o,
  output hartid_t                    result_hartid_o,
  output id_t                        result_id_o,
  output logic [4:0]                 result_rd_o,
  output logic                       result_we_o,
  output logic [$clog2(DEPTH):0]     count_o,
  output logic                       overflow_o
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;

  typedef struct packed {
    logic [XLEN-1:0] data;
    hartid_t         hartid;
    id_t             id;
    logic [4:0]      rd;
    logic            we;
  } entry_t;

  entry_t        mem_q [DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          overflow_q, overflow_d;
  logic          inflight_q, inflight_d;

  entry_t        alu_entry;
  entry_t        out_entry;
  logic          empty, full, bypass, pop, pop_fifo, push_ok, write;
  logic [CW:0]   credit;

  assign alu_entry = '{data: alu_result_i, hartid: alu_hartid_i, id: alu_id_i,
                       rd: alu_rd_i, we: alu_we_i};
  assign empty = (count_q == '0);
  assign full  = (count_q == CW'(DEPTH));

`ifdef COPRO_RESULT_BYPASS_EN
  // Empty FIFO: present the ALU result directly in the same cycle.
  assign bypass         = empty & alu_valid_i;
  assign result_valid_o = ~empty | alu_valid_i;
  assign out_entry      = !empty ? mem_q[rd_ptr_q] : (alu_valid_i ? alu_entry : '0);
`else
  assign bypass         = 1'b0;
  assign result_valid_o = ~empty;
  assign out_entry      = empty ? '0 : mem_q[rd_ptr_q];
`endif

  assign result_data_o   = out_entry.data;
  assign result_hartid_o = out_entry.hartid;
  assign result_id_o     = out_entry.id;
  assign result_rd_o     = out_entry.rd;
  assign result_we_o     = out_entry.we;
  assign count_o         = count_q;
  assign overflow_o      = overflow_q;

  assign pop      = result_valid_o & result_ready_i;
  assign pop_fifo = pop & ~empty;
  assign push_ok  = alu_valid_i & (~full | pop_fifo);
  // A bypassed result consumed this cycle never touches storage.
  assign write    = push_ok & ~(bypass & pop);

  // Credit counts the result still inside the ALU, which cannot be stalled.
  assign credit        = {1'b0, count_q} + (CW+1)'(inflight_q);
  assign issue_ready_o = (credit < (CW+1)'(DEPTH));

  always_comb begin
    wr_ptr_d   = write    ? wr_ptr_q + PW'(1) : wr_ptr_q;
    rd_ptr_d   = pop_fifo ? rd_ptr_q + PW'(1) : rd_ptr_q;
    count_d    = count_q;
    if (write && !pop_fifo) begin
      count_d = count_q + CW'(1);
    end else if (!write && pop_fifo) begin
      count_d = count_q - CW'(1);
    end
    overflow_d = overflow_q | (alu_valid_i & ~push_ok);
    inflight_d = issue_valid_i & issue_ready_o;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
      inflight_q <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
      inflight_q <= inflight_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (write && !rst_i) begin
      mem_q[wr_ptr_q] <= alu_entry;
    end
  end

endmodule

// File: tb/tb_copro_result_buffer.sv
// Randomized self-checking bench for copro_result_buffer against a queue-based reference model.
module tb_copro_result_buffer;

  localparam int DEPTH = 4;
`ifdef COPRO_RESULT_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  typedef struct {
    logic [31:0] data;
    logic [1:0]  hart;
    logic [3:0]  id;
    logic [4:0]  rd;
    logic        we;
  } ref_entry_t;

  logic        clk = 1'b0;
  logic        rst_i = 1'b1;
  logic        issue_valid_i = 1'b0;
  logic        issue_ready_o;
  logic        alu_valid_i = 1'b0;
  logic [31:0] alu_result_i = '0;
  logic [1:0]  alu_hartid_i = '0;
  logic [3:0]  alu_id_i = '0;
  logic [4:0]  alu_rd_i = '0;
  logic        alu_we_i = 1'b0;
  logic        result_valid_o;
  logic        result_ready_i = 1'b0;
  logic [31:0] result_data_o;
  logic [1:0]  result_hartid_o;
  logic [3:0]  result_id_o;
  logic [4:0]  result_rd_o;
  logic        result_we_o;
  logic [2:0]  count_o;
  logic        overflow_o;

  int n_checks = 0;
  int n_fails  = 0;

  ref_entry_t mq[$];
  bit         m_ovf = 1'b0;
  bit         m_inflight = 1'b0;

  always #5 clk = ~clk;

  copro_result_buffer #(
    .XLEN(32), .DEPTH(DEPTH), .hartid_t(logic [1:0]), .id_t(logic [3:0])
  ) dut (
    .clk_i(clk), .rst_i(rst_i),
    .issue_valid_i(issue_valid_i), .issue_ready_o(issue_ready_o),
    .alu_valid_i(alu_valid_i), .alu_result_i(alu_result_i),
    .alu_hartid_i(alu_hartid_i), .alu_id_i(alu_id_i),
    .alu_rd_i(alu_rd_i), .alu_we_i(alu_we_i),
    .result_valid_o(result_valid_o), .result_ready_i(result_ready_i),
    .result_data_o(result_data_o), .result_hartid_o(result_hartid_o),
    .result_id_o(result_id_o), .result_rd_o(result_rd_o),
    .result_we_o(result_we_o), .count_o(count_o), .overflow_o(overflow_o)
  );

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // One clock cycle: drive inputs, compare outputs with the model, then advance the model.
  task automatic step(input logic rst, input logic iv, input logic av,
                      input logic [31:0] data, input logic [1:0] hart,
                      input logic [3:0] id, input logic [4:0] rd, input logic we,
                      input logic rdy, output bit exp_ready);
    ref_entry_t cur, head;
    bit byp, exp_valid, popped;
    int n0;
    @(negedge clk);
    rst_i = rst; issue_valid_i = iv; alu_valid_i = av;
    alu_result_i = data; alu_hartid_i = hart; alu_id_i = id;
    alu_rd_i = rd; alu_we_i = we; result_ready_i = rdy;
    #1;
    cur = '{data: data, hart: hart, id: id, rd: rd, we: we};
    n0 = mq.size();
    byp = BYP && (n0 == 0) && av;
    exp_valid = (n0 > 0) || byp;
    if (n0 > 0) head = mq[0];
    else if (byp) head = cur;
    else head = '{data: '0, hart: '0, id: '0, rd: '0, we: 1'b0};
    exp_ready = (n0 + int'(m_inflight)) < DEPTH;

    check_eq("valid", 64'(result_valid_o), 64'(exp_valid));
    check_eq("data", 64'(result_data_o), 64'(head.data));
    check_eq("hartid", 64'(result_hartid_o), 64'(head.hart));
    check_eq("id", 64'(result_id_o), 64'(head.id));
    check_eq("rd", 64'(result_rd_o), 64'(head.rd));
    check_eq("we", 64'(result_we_o), 64'(head.we));
    check_eq("count", 64'(count_o), 64'(n0));
    check_eq("overflow", 64'(overflow_o), 64'(m_ovf));
    check_eq("issue_ready", 64'(issue_ready_o), 64'(exp_ready));

    popped = exp_valid && rdy;
    if (popped && !rst)
      $display("[%0t] result id=%0d hart=%0d rd=%0d we=%0b data=%08h",
               $time, head.id, head.hart, head.rd, head.we, head.data);

    @(posedge clk);
    if (rst) begin
      mq.delete();
      m_ovf = 1'b0;
      m_inflight = 1'b0;
    end else begin
      if (popped && n0 > 0) void'(mq.pop_front());
      if (av) begin
        if (byp && popped) begin
          // result handed straight to the core
        end else if (n0 < DEPTH || popped) mq.push_back(cur);
        else m_ovf = 1'b1;
      end
      m_inflight = iv && exp_ready;
    end
  endtask

  task automatic idle(input logic rdy, output bit exp_ready);
    step(1'b0, 1'b0, 1'b0, '0, '0, '0, '0, 1'b0, rdy, exp_ready);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    bit er;
    bit pend;
    logic [31:0] rdata;
    repeat (3) @(posedge clk);

    // Reset state.
    step(1'b1, 1'b0, 1'b0, '0, '0, '0, '0, 1'b0, 1'b0, er);
    idle(1'b0, er);

    // Single result through the buffer.
    step(1'b0, 1'b0, 1'b1, 32'hDEADBEEF, 2'd0, 4'd3, 5'd5, 1'b1, 1'b1, er);
    idle(1'b1, er);
    idle(1'b1, er);

    // Fill to DEPTH with the core stalled, issuing alongside.
    step(1'b0, 1'b1, 1'b0, '0, '0, '0, '0, 1'b0, 1'b0, er);
    for (int i = 1; i <= 4; i++)
      step(1'b0, 1'b1, 1'b1, 32'h1000 + i, 2'(i), 4'(i), 5'(i), 1'b1, 1'b0, er);
    idle(1'b0, er);
    check_eq("full_count", 64'(count_o), 64'd4);
    check_eq("full_issue_ready", 64'(issue_ready_o), 64'd0);

    // Full FIFO, simultaneous push and pop.
    step(1'b0, 1'b0, 1'b1, 32'h2222, 2'd2, 4'd9, 5'd9, 1'b1, 1'b1, er);
    idle(1'b0, er);
    check_eq("pushpop_count", 64'(count_o), 64'd4);
    check_eq("pushpop_ovf", 64'(overflow_o), 64'd0);

    // Full FIFO, stalled push is dropped.
    step(1'b0, 1'b0, 1'b1, 32'h3333, 2'd3, 4'd10, 5'd10, 1'b1, 1'b0, er);
    idle(1'b0, er);
    check_eq("drop_ovf", 64'(overflow_o), 64'd1);
    check_eq("drop_head_id", 64'(result_id_o), 64'd2);
    repeat (5) idle(1'b1, er);
    check_eq("ovf_sticky", 64'(overflow_o), 64'd1);

    // NOP result.
    step(1'b0, 1'b0, 1'b1, 32'h0, 2'd0, 4'd7, 5'd0, 1'b0, 1'b0, er);
    idle(1'b1, er);
    idle(1'b1, er);

    // Reset with three entries queued.
    for (int i = 0; i < 3; i++)
      step(1'b0, 1'b1, 1'b1, $urandom, 2'(i), 4'(i + 4), 5'(i + 4), 1'b1, 1'b0, er);
    step(1'b1, 1'b1, 1'b0, '0, '0, '0, '0, 1'b0, 1'b0, er);
    idle(1'b0, er);
    check_eq("rst_count", 64'(count_o), 64'd0);
    check_eq("rst_issue_ready", 64'(issue_ready_o), 64'd1);

    // Compliant issuer: ALU result follows each accepted issue by one cycle.
    pend = 1'b0;
    for (int c = 0; c < 300; c++) begin
      logic iv;
      iv = ($urandom_range(3) != 0);
      rdata = $urandom;
      step(1'b0, iv, pend, rdata, 2'($urandom), 4'($urandom), 5'($urandom),
           1'($urandom), ($urandom_range(2) != 0), er);
      pend = iv && er;
    end
    check_eq("compliant_no_ovf", 64'(overflow_o), 64'd0);

    // Unconstrained traffic with occasional reset.
    for (int c = 0; c < 250; c++) begin
      rdata = $urandom;
      step(($urandom_range(49) == 0), 1'($urandom), ($urandom_range(3) != 0), rdata,
           2'($urandom), 4'($urandom), 5'($urandom), 1'($urandom),
           ($urandom_range(2) == 0), er);
    end
    repeat (6) idle(1'b1, er);
    check_eq("drained_valid", 64'(result_valid_o), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
